// File: rtl/scanlines_ctrl.sv
// scanlines_ctrl: frame-synchronous scanline mode and line-count controller.
// Optional per-frame phase toggle: SCANLINES_CTRL_ALT_PHASE_EN.
module scanlines_ctrl #(
    parameter int         MAX_LINES    = 288,
    parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
    input  logic        iPCLK,
    input  logic        iRST_N,
    input  logic [1:0]  iCFG_MODE,
    input  logic        iCFG_WR,
    input  logic        iVS,
    input  logic        iDE,
    output logic [1:0]  oSCANLINES,
    output logic        oBUSY,
    output logic [10:0] oLINES,
    output logic        oFRAME_START,
    output logic        oPHASE
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    localparam logic [10:0] MaxLines = 11'(MAX_LINES);

    state_t      state;
    state_t      stateNext;
    logic [1:0]  active;
    logic [1:0]  activeNext;
    logic [1:0]  pending;
    logic [1:0]  pendingNext;
    logic        vsD;
    logic        deD;
    logic [10:0] lineCnt;
    logic [10:0] lineCntNext;
    logic        fb;
    logic        ln;
    logic        tooMany;

    assign fb      = vsD & ~iVS;
    assign ln      = ~deD & iDE;
    assign tooMany = lineCnt > MaxLines;
    assign oBUSY   = (state == PENDING);

    always_comb begin
        stateNext   = state;
        activeNext  = active;
        pendingNext = pending;
        case (state)
            IDLE: begin
                if (iCFG_WR) begin
                    pendingNext = iCFG_MODE;
                    stateNext   = PENDING;
                end
            end
            PENDING: begin
                // A write landing on the boundary waits for the next frame
                if (fb) begin
                    activeNext = pending;
                    stateNext  = IDLE;
                end
                if (iCFG_WR) begin
                    pendingNext = iCFG_MODE;
                    stateNext   = PENDING;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        lineCntNext = lineCnt;
        if (fb) begin
            lineCntNext = {10'd0, ln};
        end else if (ln && lineCnt != 11'h7FF) begin
            lineCntNext = lineCnt + 11'd1;
        end
    end

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            active  <= DEFAULT_MODE;
            pending <= DEFAULT_MODE;
            vsD     <= 1'b0;
            deD     <= 1'b0;
            lineCnt <= 11'd0;
        end else begin
            state   <= stateNext;
            active  <= activeNext;
            pending <= pendingNext;
            vsD     <= iVS;
            deD     <= iDE;
            lineCnt <= lineCntNext;
        end
    end

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oSCANLINES   <= DEFAULT_MODE;
            oLINES       <= 11'd0;
            oFRAME_START <= 1'b0;
        end else begin
            oFRAME_START <= fb;
            if (fb) begin
                oLINES     <= lineCnt;
                oSCANLINES <= tooMany ? 2'd0 : activeNext;
            end
        end
    end

`ifdef SCANLINES_CTRL_ALT_PHASE_EN
    logic phase;

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            phase <= 1'b0;
        end else if (fb) begin
            phase <= ~phase;
        end
    end

    assign oPHASE = phase;
`else
    assign oPHASE = 1'b0;
`endif

endmodule

// File: tb/tb_scanlines_ctrl.sv
// tb_scanlines_ctrl: directed bench with a frame-result scoreboard.
// Phase expectations follow SCANLINES_CTRL_ALT_PHASE_EN.
module tb_scanlines_ctrl;

    logic        iPCLK;
    logic        iRST_N;
    logic [1:0]  iCFG_MODE;
    logic        iCFG_WR;
    logic        iVS;
    logic        iDE;
    logic [1:0]  oSCANLINES;
    logic        oBUSY;
    logic [10:0] oLINES;
    logic        oFRAME_START;
    logic        oPHASE;

    typedef struct {
        int lines;
        int mode;
        int phase;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mActive;
    int   mPending;
    int   mCnt;
    int   mPhase;
    bit   mBusy;

    scanlines_ctrl #(
        .MAX_LINES   (288),
        .DEFAULT_MODE(2'd2)
    ) dut (
        .iPCLK       (iPCLK),
        .iRST_N      (iRST_N),
        .iCFG_MODE   (iCFG_MODE),
        .iCFG_WR     (iCFG_WR),
        .iVS         (iVS),
        .iDE         (iDE),
        .oSCANLINES  (oSCANLINES),
        .oBUSY       (oBUSY),
        .oLINES      (oLINES),
        .oFRAME_START(oFRAME_START),
        .oPHASE      (oPHASE)
    );

    initial iPCLK = 1'b0;
    always #5 iPCLK = ~iPCLK;

    task automatic step();
        @(posedge iPCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mActive  = 2;
        mPending = 2;
        mBusy    = 1'b0;
        mCnt     = 0;
        mPhase   = 0;
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            iDE = 1'b1;
            repeat (3) step();
            iDE = 1'b0;
            repeat (2) step();
            mCnt = (mCnt == 2047) ? 2047 : mCnt + 1;
        end
    endtask

    task automatic cfgWrite(input logic [1:0] m);
        iCFG_MODE = m;
        iCFG_WR   = 1'b1;
        step();
        iCFG_WR   = 1'b0;
        mPending  = m;
        mBusy     = 1'b1;
    endtask

    task automatic boundary(input string tag, input bit wr,
                            input logic [1:0] m);
        exp_t e;
        exp_t got;
        int   found;
        int   lat;
        iVS = 1'b1;
        repeat (3) step();
        e.lines = mCnt;
        mCnt    = 0;
        if (mBusy) mActive = mPending;
        mBusy = 1'b0;
        if (wr) begin
            mPending = m;
            mBusy    = 1'b1;
        end
`ifdef SCANLINES_CTRL_ALT_PHASE_EN
        mPhase ^= 1;
`endif
        e.mode  = (e.lines > 288) ? 0 : mActive;
        e.phase = mPhase;
        q.push_back(e);
        iVS = 1'b0;
        if (wr) begin
            iCFG_MODE = m;
            iCFG_WR   = 1'b1;
        end
        step();
        iCFG_WR = 1'b0;
        found = 0;
        lat   = 0;
        for (int k = 0; k < 4; k++) begin
            if (oFRAME_START) begin
                found = 1;
                lat   = k;
                break;
            end
            step();
        end
        check({tag, "_fs_seen"}, found, 1);
        if (found == 1) begin
            got = q.pop_front();
            check({tag, "_fs_lat"}, lat, 0);
            check({tag, "_lines"}, oLINES, got.lines);
            check({tag, "_mode"}, oSCANLINES, got.mode);
            check({tag, "_phase"}, oPHASE, got.phase);
            check({tag, "_busy"}, oBUSY, mBusy);
            step();
            check({tag, "_fs_pulse"}, oFRAME_START, 0);
        end else begin
            void'(q.pop_front());
        end
    endtask

    initial begin
        iRST_N    = 1'b0;
        iCFG_MODE = 2'd0;
        iCFG_WR   = 1'b0;
        iVS       = 1'b0;
        iDE       = 1'b0;
        modelReset();
        repeat (3) step();
        check("rst_mode", oSCANLINES, 2);
        check("rst_busy", oBUSY, 0);
        check("rst_lines", oLINES, 0);
        check("rst_fs", oFRAME_START, 0);
        check("rst_phase", oPHASE, 0);
        iRST_N = 1'b1;
        step();

        boundary("f0", 1'b0, 2'd0);
        lines(10);
        boundary("f1", 1'b0, 2'd0);

        lines(50);
        cfgWrite(2'd3);
        check("wr3_busy", oBUSY, 1);
        check("wr3_hold", oSCANLINES, 2);
        lines(50);
        check("wr3_hold2", oSCANLINES, 2);
        boundary("apply3", 1'b0, 2'd0);

        lines(20);
        cfgWrite(2'd3);
        cfgWrite(2'd1);
        lines(20);
        check("lastwin_hold", oSCANLINES, 3);
        boundary("lastwin", 1'b0, 2'd0);

        lines(15);
        cfgWrite(2'd0);
        boundary("coinc", 1'b1, 2'd3);
        lines(15);
        check("coinc_hold", oSCANLINES, 0);
        boundary("coinc_next", 1'b0, 2'd0);

        lines(224);
        boundary("l224", 1'b0, 2'd0);
        lines(480);
        boundary("l480", 1'b0, 2'd0);
        lines(224);
        boundary("l224b", 1'b0, 2'd0);
        lines(288);
        boundary("l288", 1'b0, 2'd0);
        lines(289);
        boundary("l289", 1'b0, 2'd0);
        lines(224);
        boundary("l224c", 1'b0, 2'd0);

        lines(30);
        cfgWrite(2'd1);
        check("prerst_busy", oBUSY, 1);
        iRST_N = 1'b0;
        #2;
        modelReset();
        check("midrst_busy", oBUSY, 0);
        check("midrst_mode", oSCANLINES, 2);
        check("midrst_lines", oLINES, 0);
        check("midrst_phase", oPHASE, 0);
        step();
        iRST_N = 1'b1;
        step();
        lines(40);
        boundary("postrst", 1'b0, 2'd0);
        lines(12);
        boundary("postrst2", 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
